uart_txd_cfg: RTL and testbench

UART_TXD_CFG -- requirements
Module: uart_txd_cfg

---
 rtl/uart_txd_cfg.sv | 205 ++++++++++++++++++++
 tb/tb_uart_txd_cfg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txd_cfg.sv
// uart_txd_cfg: parameterised UART transmitter with a small transmit FIFO.
// Rev 1.0 - initial release.
`default_nettype none

module uart_txd_cfg #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int MSB_FIRST       = 0,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          valid,
  output logic                          ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int DIV   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 2);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  logic [2:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic                 bit_done;
  logic                 stop_end;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 out_bit;
  logic [DATA_BITS-1:0] shifted;

  assign ready    = (level != LVL_FULL);
  assign busy     = (state != ST_IDLE);
  assign bit_done = (baud_cnt == BAUD_LAST);
  assign stop_end = (state == ST_STOP) && bit_done && (bit_cnt == STOP_LAST);
  assign push     = valid && ready;
  assign pop      = (level != '0) && ((state == ST_IDLE) || stop_end);
  assign head     = mem[rd_ptr];
  assign head_par = (^head) ^ PAR_ODD;

  // The serialiser always emits the bit at one end of shreg and shifts toward it.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign out_bit = shreg[DATA_BITS-1];
      assign shifted = {shreg[DATA_BITS-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit = shreg[0];
      assign shifted = {1'b0, shreg[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      txd      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          txd      <= 1'b1;
          if (pop) begin
            shreg   <= head;
            par_bit <= head_par;
            state   <= ST_START;
            txd     <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= out_bit;
            shreg    <= shifted;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= ST_PAR;
                txd   <= par_bit;
              end else begin
                state <= ST_STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              txd     <= out_bit;
              shreg   <= shifted;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        ST_PAR: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_STOP;
            txd      <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              // Chain straight into the next frame when a word is waiting.
              if (pop) begin
                shreg   <= head;
                par_bit <= head_par;
                state   <= ST_START;
                txd     <= 1'b0;
              end else begin
                state <= ST_IDLE;
                txd   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          txd      <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_txd_cfg.sv
// tb_uart_txd_cfg: directed checks of uart_txd_cfg with DIV = 4 across frame formats.
`default_nettype none

module tb_uart_txd_cfg;

  logic            clk;
  logic            rst;
  logic [4:0][7:0] din;
  logic [4:0]      valid;
  logic [4:0]      ready;
  logic [4:0]      txd;
  logic [4:0]      busy;
  logic [4:0][2:0] level;

  int n_total;
  int n_bad;

  logic [127:0] cap [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: 8N1 LSB first, 1: 8E1, 2: 8O1, 3: 8N2, 4: 8N1 MSB first
  uart_txd_cfg #(.CLOCK_FREQUENCY(8), .BAUD_RATE(2)) u_n1 (
    .clk(clk), .rst(rst), .din(din[0]), .valid(valid[0]), .ready(ready[0]),
    .txd(txd[0]), .busy(busy[0]), .level(level[0]));
  uart_txd_cfg #(.CLOCK_FREQUENCY(8), .BAUD_RATE(2), .PARITY(1)) u_e1 (
    .clk(clk), .rst(rst), .din(din[1]), .valid(valid[1]), .ready(ready[1]),
    .txd(txd[1]), .busy(busy[1]), .level(level[1]));
  uart_txd_cfg #(.CLOCK_FREQUENCY(8), .BAUD_RATE(2), .PARITY(2)) u_o1 (
    .clk(clk), .rst(rst), .din(din[2]), .valid(valid[2]), .ready(ready[2]),
    .txd(txd[2]), .busy(busy[2]), .level(level[2]));
  uart_txd_cfg #(.CLOCK_FREQUENCY(8), .BAUD_RATE(2), .STOP_BITS(2)) u_n2 (
    .clk(clk), .rst(rst), .din(din[3]), .valid(valid[3]), .ready(ready[3]),
    .txd(txd[3]), .busy(busy[3]), .level(level[3]));
  uart_txd_cfg #(.CLOCK_FREQUENCY(8), .BAUD_RATE(2), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din[4]), .valid(valid[4]), .ready(ready[4]),
    .txd(txd[4]), .busy(busy[4]), .level(level[4]));

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // seq holds line bits with the first bit in bit 0; sample 0 is the idle cycle before the start bit.
  function automatic logic [127:0] expand(input logic [31:0] seq, input int nbits);
    logic [127:0] e;
    e = '1;
    for (int k = 0; k < nbits; k++)
      for (int c = 0; c < 4; c++)
        e[1 + 4*k + c] = seq[k];
    return e;
  endfunction

  task automatic capture(input int n);
    for (int j = 0; j < 5; j++) cap[j] = '1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int j = 0; j < 5; j++) cap[j][i] = txd[j];
    end
  endtask

  task automatic rx_frame(output logic [7:0] b, output logic ok);
    int guard;
    logic start_ok;
    guard = 0;
    b = '0;
    ok = 1'b0;
    @(negedge clk);
    while (txd[0] !== 1'b0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (txd[0] === 1'b0) begin
      repeat (2) @(negedge clk);
      start_ok = (txd[0] === 1'b0);
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(negedge clk);
        b[k] = txd[0];
      end
      repeat (4) @(negedge clk);
      ok = start_ok && (txd[0] === 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] words [6];
    int zeros;
    int guard;
    n_total = 0;
    n_bad   = 0;
    words[0] = 8'h5A; words[1] = 8'h01; words[2] = 8'hFF;
    words[3] = 8'h80; words[4] = 8'hC3; words[5] = 8'h3E;
    din   = '0;
    valid = '0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_txd",   txd[0],   1);
    check_eq("rst_busy",  busy[0],  0);
    check_eq("rst_level", level[0], 0);
    check_eq("rst_ready", ready[0], 1);
    rst = 1'b0;

    // Six words from reset: one pops, four fill, the sixth waits for space.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic acc;
          int g;
          din[0] = words[i];
          valid[0] = 1'b1;
          acc = 1'b0;
          g = 0;
          while (!acc && g < 200) begin
            @(negedge clk);
            acc = ready[0];
            @(posedge clk);
            #1;
            g++;
          end
          if (!acc) check_eq($sformatf("wr_timeout%0d", i), 0, 1);
          if (i == 0) check_eq("level_first", level[0], 1);
          if (i == 4) begin
            check_eq("level_full", level[0], 4);
            check_eq("ready_full", ready[0], 0);
          end
        end
        valid[0] = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          logic [7:0] b;
          logic ok;
          rx_frame(b, ok);
          check_eq($sformatf("frame%0d", i), {ok, b}, {1'b1, words[i]});
        end
      end
    join

    guard = 0;
    while (busy[0] !== 1'b0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    check_eq("idle_after_burst", busy[0], 0);
    check_eq("level_after_burst", level[0], 0);

    // Two words back-to-back: 0xA5 then 0x3C with no gap between frames.
    @(posedge clk); #1;
    din[0] = 8'hA5; valid[0] = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        din[0] = 8'h3C;
        @(posedge clk); #1;
        valid[0] = 1'b0;
      end
      capture(84);
    join
    check_eq("b2b_a5_3c", cap[0], expand({10'b1001111000, 10'b1101001010}, 20));

    // Parity, two stop bits and MSB-first variants together.
    @(posedge clk); #1;
    din[1] = 8'h07; din[2] = 8'h07; din[3] = 8'h07; din[4] = 8'h0F;
    valid[4:1] = 4'b1111;
    @(posedge clk); #1;
    fork
      begin
        valid[4:1] = 4'b0100;
        din[3] = 8'h00;
        @(posedge clk); #1;
        valid[4:1] = 4'b0000;
      end
      capture(92);
    join
    check_eq("even_par_07", cap[1], expand(32'b11000001110, 11));
    check_eq("odd_par_07",  cap[2], expand(32'b10000001110, 11));
    check_eq("two_stop",    cap[3], expand({11'b11000000000, 11'b11000001110}, 22));
    check_eq("msb_first_0f", cap[4], expand(32'b1111100000, 10));

    // Reset in the middle of a frame with two words still queued.
    @(posedge clk); #1;
    din[0] = 8'hA5; valid[0] = 1'b1;
    @(posedge clk); #1;
    din[0] = 8'h3C;
    @(posedge clk); #1;
    din[0] = 8'h11;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    check_eq("level_two_queued", level[0], 2);
    repeat (9) @(posedge clk);
    #2;
    check_eq("txd_pre_rst", txd[0], 0);
    check_eq("busy_pre_rst", busy[0], 1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_txd",   txd[0],   1);
    check_eq("rst_mid_level", level[0], 0);
    check_eq("rst_mid_ready", ready[0], 1);
    check_eq("rst_mid_busy",  busy[0],  0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) zeros++;
    end
    check_eq("quiet_after_rst", zeros, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
